nx_fifo_ctrl_1r1w: RTL and testbench

Client-side controller for a registered-input, registered-output 1R1W RAM macro: it turns a valid/ready push stream and a valid/ready pop stream into the active-low write/read port protocol of the RAM. It absorbs the RAM's 2-cycle read latency with a 4-entry output prefetch buffer so pops sustain one per cycle. It sits beside each 1R1W RAM instance used as a FIFO in the datapath.

---
 rtl/nx_fifo_ctrl_1r1w.sv | 145 ++++++++++++++
 tb/tb_nx_fifo_ctrl_1r1w.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nx_fifo_ctrl_1r1w.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nx_fifo_ctrl_1r1w: valid/ready FIFO controller for a 2-cycle 1R1W    |
// | RAM with 4-entry prefetch. Option macro: NX_FIFO_CTRL_OVF_CHK_EN.    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module nx_fifo_ctrl_1r1w #(
  parameter int WIDTH = 83,
  parameter int DEPTH = 168,
  parameter int AW    = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [WIDTH-1:0] wr_data,
  output logic             rd_valid,
  input  logic             rd_ready,
  output logic [WIDTH-1:0] rd_data,
  output logic [AW+1:0]    count,
  output logic             ram_web,
  output logic [AW-1:0]    ram_wa,
  output logic [WIDTH-1:0] ram_din,
  output logic [WIDTH-1:0] ram_bwe,
  output logic             ram_reb,
  output logic [AW-1:0]    ram_ra,
  input  logic [WIDTH-1:0] ram_dout,
  output logic             overflow
);
  localparam logic [AW-1:0] c_last_addr = AW'(DEPTH - 1);
  localparam logic [AW:0]   c_depth     = (AW+1)'(DEPTH);

  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_ram_occ;
  logic [AW:0]      r_avail;
  logic [1:0]       r_vis;
  logic [1:0]       r_infl;
  logic [WIDTH-1:0] r_buf [4];
  logic [1:0]       r_buf_wi;
  logic [1:0]       r_buf_ri;
  logic [2:0]       r_buf_occ;
  logic [AW+1:0]    r_count;
  logic             r_wr_ready;
  logic             r_web;
  logic [AW-1:0]    r_wa;
  logic [WIDTH-1:0] r_din;

  logic             w_push;
  logic             w_pop;
  logic             w_issue;
  logic [3:0]       w_pend;
  logic [AW:0]      w_ram_occ_nxt;

  assign w_push = wr_valid & r_wr_ready;
  assign w_pop  = (r_buf_occ != 3'd0) & rd_ready;
  // Buffer slots already committed: held entries plus reads still in the RAM pipe.
  assign w_pend  = 4'(r_buf_occ) + 4'(r_infl[0]) + 4'(r_infl[1]);
  assign w_issue = (r_avail != '0) && (w_pend < (4'd4 + 4'(w_pop)));
  assign w_ram_occ_nxt = r_ram_occ + (AW+1)'(w_push) - (AW+1)'(w_issue);

  assign wr_ready = r_wr_ready;
  assign rd_valid = (r_buf_occ != 3'd0);
  assign rd_data  = r_buf[r_buf_ri];
  assign count    = r_count;
  assign ram_web  = r_web;
  assign ram_wa   = r_wa;
  assign ram_din  = r_din;
  assign ram_bwe  = '1;
  assign ram_reb  = ~w_issue;
  assign ram_ra   = r_rptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr     <= '0;
      r_web      <= 1'b1;
      r_wa       <= '0;
      r_din      <= '0;
      r_ram_occ  <= '0;
      r_wr_ready <= 1'b0;
      r_count    <= '0;
    end else begin
      r_web      <= ~w_push;
      r_ram_occ  <= w_ram_occ_nxt;
      r_wr_ready <= (w_ram_occ_nxt < c_depth);
      r_count    <= r_count + (AW+2)'(w_push) - (AW+2)'(w_pop);
      if (w_push) begin
        r_wa   <= r_wptr;
        r_din  <= wr_data;
        r_wptr <= (r_wptr == c_last_addr) ? '0 : r_wptr + 1'b1;
      end
    end
  end

  // An entry is readable once the RAM input flop and the array write are done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vis   <= '0;
      r_avail <= '0;
      r_rptr  <= '0;
      r_infl  <= '0;
    end else begin
      r_vis   <= {r_vis[0], w_push};
      r_avail <= r_avail + (AW+1)'(r_vis[1]) - (AW+1)'(w_issue);
      r_infl  <= {r_infl[0], w_issue};
      if (w_issue)
        r_rptr <= (r_rptr == c_last_addr) ? '0 : r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++)
        r_buf[i] <= '0;
      r_buf_wi  <= '0;
      r_buf_ri  <= '0;
      r_buf_occ <= '0;
    end else begin
      if (r_infl[1]) begin
        r_buf[r_buf_wi] <= ram_dout;
        r_buf_wi        <= r_buf_wi + 2'd1;
      end
      if (w_pop)
        r_buf_ri <= r_buf_ri + 2'd1;
      r_buf_occ <= r_buf_occ + 3'(r_infl[1]) - 3'(w_pop);
    end
  end

`ifdef NX_FIFO_CTRL_OVF_CHK_EN
  logic r_overflow;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_overflow <= 1'b0;
    else if (wr_valid && !r_wr_ready)
      r_overflow <= 1'b1;
  end

  assign overflow = r_overflow;
`else
  assign overflow = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_nx_fifo_ctrl_1r1w.sv
`default_nettype none
`timescale 1ns/1ps
// tb_nx_fifo_ctrl_1r1w: scoreboard bench with a behavioural 2-cycle-latency RAM model.
module tb_nx_fifo_ctrl_1r1w;
  localparam int WIDTH = 83;
  localparam int DEPTH = 168;
  localparam int AW    = 8;
`ifdef NX_FIFO_CTRL_OVF_CHK_EN
  localparam logic OVF_EXP = 1'b1;
`else
  localparam logic OVF_EXP = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             wr_valid = 1'b0;
  logic             wr_ready;
  logic [WIDTH-1:0] wr_data = '0;
  logic             rd_valid;
  logic             rd_ready = 1'b0;
  logic [WIDTH-1:0] rd_data;
  logic [AW+1:0]    count;
  logic             ram_web;
  logic [AW-1:0]    ram_wa;
  logic [WIDTH-1:0] ram_din;
  logic [WIDTH-1:0] ram_bwe;
  logic             ram_reb;
  logic [AW-1:0]    ram_ra;
  logic [WIDTH-1:0] ram_dout;
  logic             overflow;

  nx_fifo_ctrl_1r1w #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count),
    .ram_web(ram_web), .ram_wa(ram_wa), .ram_din(ram_din), .ram_bwe(ram_bwe),
    .ram_reb(ram_reb), .ram_ra(ram_ra), .ram_dout(ram_dout),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic logic [WIDTH-1:0] rnd_word();
    return WIDTH'({$urandom(), $urandom(), $urandom()});
  endfunction

  // RAM macro: inputs flopped, array written one cycle later, read data flopped out.
  logic [WIDTH-1:0] mem [DEPTH];
  logic             m_web_q = 1'b1;
  logic             m_reb_q = 1'b1;
  logic [AW-1:0]    m_wa_q, m_ra_q;
  logic [WIDTH-1:0] m_din_q;

  always @(posedge clk) begin
    m_web_q <= ram_web;
    m_wa_q  <= ram_wa;
    m_din_q <= ram_din;
    m_reb_q <= ram_reb;
    m_ra_q  <= ram_ra;
    if (!m_web_q) mem[m_wa_q] <= m_din_q;
    if (!m_reb_q) ram_dout <= mem[m_ra_q];
    else          ram_dout <= rnd_word();
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Scoreboard: expected head-of-line data in push order.
  logic [WIDTH-1:0] sb[$];
  int  cyc = 0;
  int  exp_wa = 0, exp_ra = 0, prev_wa = -1, prev_ra = -1;
  bit  saw_wa_wrap = 0, saw_ra_wrap = 0;
  bit  stream_on = 0;
  int  s_pops = 0, s_first_push = -1, s_first_pop = -1, s_last_pop = -1;

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      chk("rst_rd_valid", rd_valid, 0);
      chk("rst_count", count, 0);
      chk("rst_ram_web", ram_web, 1);
      chk("rst_ram_reb", ram_reb, 1);
      chk("rst_overflow", overflow, 0);
      sb.delete();
      exp_wa = 0; exp_ra = 0; prev_wa = -1; prev_ra = -1;
    end else begin
      chk("count", count, sb.size());
      if (!ram_web) begin
        chk("ram_wa", ram_wa, exp_wa);
        if (prev_wa == DEPTH-1 && ram_wa == 0) saw_wa_wrap = 1;
        prev_wa = ram_wa;
        exp_wa = (exp_wa + 1) % DEPTH;
      end
      if (!ram_reb) begin
        chk("ram_ra", ram_ra, exp_ra);
        if (prev_ra == DEPTH-1 && ram_ra == 0) saw_ra_wrap = 1;
        prev_ra = ram_ra;
        exp_ra = (exp_ra + 1) % DEPTH;
      end
      if (rd_valid && rd_ready) begin
        if (sb.size() == 0) chk("pop_on_empty", 1, 0);
        else chk("rd_data", rd_data, sb.pop_front());
        if (stream_on) begin
          if (s_first_pop < 0) s_first_pop = cyc;
          s_last_pop = cyc;
          s_pops++;
        end
      end
      if (wr_valid && wr_ready) begin
        sb.push_back(wr_data);
        if (stream_on && s_first_push < 0) s_first_push = cyc;
      end
    end
  end

  task automatic push_word(input logic [WIDTH-1:0] d);
    bit acc = 0;
    wr_valid = 1'b1;
    wr_data  = d;
    for (int k = 0; k < 2000 && !acc; k++) begin
      @(negedge clk);
      acc = wr_ready;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    if (!acc) chk("push_timeout", 0, 1);
  endtask

  task automatic wait_drain(input string name);
    bit done = 0;
    for (int k = 0; k < 3000 && !done; k++) begin
      @(negedge clk);
      done = (count == 0) && !rd_valid && (sb.size() == 0);
    end
    @(posedge clk); #1;
    chk(name, done, 1);
  endtask

  // Single push of d at the current cycle (cycle 0); expects a pop at cycle 6.
  task automatic single_push(input string tag, input logic [WIDTH-1:0] d);
    rd_ready = 1'b1; wr_valid = 1'b1; wr_data = d;
    @(posedge clk); #1; wr_valid = 1'b0;
    @(negedge clk);                                   // cycle 1
    chk({tag, "_web_c1"}, ram_web, 0);
    chk({tag, "_din_c1"}, ram_din, d);
    @(negedge clk);                                   // cycle 2
    chk({tag, "_reb_c2"}, ram_reb, 1);
    @(negedge clk);                                   // cycle 3
    chk({tag, "_reb_c3"}, ram_reb, 0);
    @(negedge clk); @(negedge clk);                   // cycle 5
    chk({tag, "_valid_c5"}, rd_valid, 0);
    @(negedge clk);                                   // cycle 6
    chk({tag, "_valid_c6"}, rd_valid, 1);
    chk({tag, "_data_c6"}, rd_data, d);
    @(negedge clk);
    chk({tag, "_count_after"}, count, 0);
    @(posedge clk); #1;
  endtask

  initial begin
    int sent;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_data", rd_data, 0);
    chk("rst_ram_wa", ram_wa, 0);
    chk("rst_ram_ra", ram_ra, 0);
    chk("rst_ram_din", ram_din, 0);
    chk("ram_bwe", ram_bwe, {WIDTH{1'b1}});
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("wr_ready_after_rst", wr_ready, 1);

    // Single entry latency; first write lands at address 0.
    single_push("t1", 83'h1234);

    // Fill to capacity with no pops, then overflow attempt, then drain in order.
    rd_ready = 1'b0;
    for (int i = 0; i < DEPTH + 4; i++) push_word(WIDTH'(i));
    @(negedge clk);
    chk("full_wr_ready", wr_ready, 0);
    chk("full_count", count, DEPTH + 4);
    @(posedge clk); #1;
    wr_valid = 1'b1; wr_data = rnd_word();
    repeat (3) @(negedge clk);
    chk("ovf_flag", overflow, OVF_EXP);
    chk("ovf_count", count, DEPTH + 4);
    @(posedge clk); #1;
    wr_valid = 1'b0; rd_ready = 1'b1;
    wait_drain("full_drain");
    chk("ovf_sticky", overflow, OVF_EXP);

    // Streaming: one push per cycle must give one pop per cycle with no bubbles.
    stream_on = 1;
    for (int i = 0; i < 1000; i++) push_word(rnd_word());
    wait_drain("stream_drain");
    stream_on = 0;
    chk("stream_pops", s_pops, 1000);
    chk("stream_no_bubble", s_last_pop - s_first_pop + 1, 1000);
    chk("stream_latency", s_first_pop - s_first_push, 6);
    chk("wa_wrap_seen", saw_wa_wrap, 1);
    chk("ra_wrap_seen", saw_ra_wrap, 1);

    // Random backpressure on both sides.
    sent = 0;
    for (int c = 0; c < 40000 && !(sent >= 5000 && sb.size() == 0 && count == 0); c++) begin
      wr_valid = (sent < 5000) && ($urandom_range(1, 0) == 1);
      wr_data  = rnd_word();
      rd_ready = ($urandom_range(1, 0) == 1);
      @(negedge clk);
      if (wr_valid && wr_ready) sent++;
      @(posedge clk); #1;
    end
    wr_valid = 1'b0;
    chk("rand_sent", sent, 5000);
    chk("rand_drained", sb.size(), 0);

    // Asynchronous reset while streaming with reads in flight.
    rd_ready = 1'b1;
    for (int i = 0; i < 20; i++) push_word(rnd_word());
    wr_valid = 1'b1; wr_data = rnd_word();
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_web", ram_web, 1);
    chk("mid_rst_reb", ram_reb, 1);
    chk("mid_rst_rd_valid", rd_valid, 0);
    chk("mid_rst_count", count, 0);
    chk("mid_rst_wr_ready", wr_ready, 0);
    wr_valid = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    single_push("t5", 83'hABCD);
    repeat (10) @(negedge clk);
    chk("post_rst_idle", rd_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_chk);
    $fatal(1);
  end

endmodule
`default_nettype wire
